// File: rtl/dbus_mem_model.sv
// Memory-backed dbus responder: byte-masked writes, in-order reads answered LATENCY cycles after acceptance.
// cmd_ready drops while DEPTH reads are outstanding; held responses keep rsp_valid/rdata stable until taken.
module dbus_mem_model #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_payload_address,
  input  logic        cmd_payload_write,
  input  logic [31:0] cmd_payload_wdata,
  input  logic [3:0]  cmd_payload_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_rdata
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]     data;
    logic [CD_W-1:0] cd;
  } q_entry_t;

  logic [31:0]      mem [WORDS];
  q_entry_t         q   [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [IDX_W-1:0] idx;
  logic             cmd_fire;
  logic             push;
  logic             pop;
  logic             unused_addr;

  // Bits outside the word index alias, so they are deliberately dropped.
  assign idx         = cmd_payload_address[2 +: IDX_W];
  assign unused_addr = ^{cmd_payload_address[31:IDX_W+2], cmd_payload_address[1:0]};

  assign cmd_ready = !reset && (count < CNT_FULL);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign push      = cmd_fire && !cmd_payload_write;

  assign rsp_valid         = (count != '0) && (q[head].cd == '0);
  assign pop               = rsp_valid && rsp_ready;
  assign rsp_payload_rdata = rsp_valid ? q[head].data : '0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // The array survives reset so pre-reset contents stay readable.
  always_ff @(posedge clk) begin
    if (cmd_fire && cmd_payload_write) begin
      for (int b = 0; b < 4; b++) begin
        if (cmd_payload_wmask[b]) begin
          mem[idx][8*b +: 8] <= cmd_payload_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].cd != '0) begin
          q[i].cd <= q[i].cd - 1'b1;
        end
      end
      // Data is captured at acceptance; later writes cannot reach a queued entry.
      if (push) begin
        q[tail] <= '{data: mem[idx], cd: CD_INIT};
        tail    <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_mem_model.sv
// Directed bench for dbus_mem_model: expected read data queued at command acceptance, checked as responses fire.
module tb_dbus_mem_model;

  localparam int WORDS   = 1024;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_payload_address;
  logic        cmd_payload_write;
  logic [31:0] cmd_payload_wdata;
  logic [3:0]  cmd_payload_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_rdata;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  dbus_mem_model #(.WORDS(WORDS), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_payload_address (cmd_payload_address),
    .cmd_payload_write   (cmd_payload_write),
    .cmd_payload_wdata   (cmd_payload_wdata),
    .cmd_payload_wmask   (cmd_payload_wmask),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_payload_rdata   (rsp_payload_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds a command until accepted; read expectations are queued at acceptance.
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp);
    int n = 0;
    cmd_valid           = 1'b1;
    cmd_payload_write   = w;
    cmd_payload_address = a;
    cmd_payload_wdata   = d;
    cmd_payload_wmask   = m;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("cmd_accept_timeout", 32'd0, 32'd1);
    else if (!w) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    drive(1'b1, a, d, m, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'd0, 4'h0, exp);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  // Response monitor: a response fires at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else chk("rdata", rsp_payload_rdata, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset               = 1'b1;
    cmd_valid           = 1'b0;
    cmd_payload_address = '0;
    cmd_payload_write   = 1'b0;
    cmd_payload_wdata   = '0;
    cmd_payload_wmask   = '0;
    rsp_ready           = 1'b1;

    #12;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_payload_rdata, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Full write then read: response appears exactly LATENCY cycles after acceptance.
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10, 32'hDEADBEEF);
    for (int i = 0; i < LATENCY - 1; i++) begin
      chk("latency_early", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("latency_valid", {31'd0, rsp_valid}, 32'd1);
    chk("latency_rdata", rsp_payload_rdata, 32'hDEADBEEF);
    drain();

    // Byte mask.
    wr(32'h20, 32'hFFFFFFFF, 4'hF);
    wr(32'h20, 32'h00000000, 4'h5);
    rd(32'h20, 32'hFF00FF00);
    drain();

    // Backpressure: fill the queue with rsp_ready low, then stream out in order.
    for (int i = 0; i < DEPTH; i++) wr(32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF);
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) rd(32'(4 * i), 32'h1000_0000 + 32'(i));
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid           = 1'b1;
    cmd_payload_write   = 1'b0;
    cmd_payload_address = 32'h10;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    chk("ready_before_pop", {31'd0, cmd_ready}, 32'd0);
    chk("head_valid", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    chk("stream_valid_1", {31'd0, rsp_valid}, 32'd1);
    rd(32'h10, 32'hDEADBEEF);
    for (int i = 2; i <= DEPTH; i++) begin
      chk("stream_valid_n", {31'd0, rsp_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    drain();

    // Read-then-write hazard: queued data is the pre-write value.
    wr(32'h40, 32'h11, 4'hF);
    rd(32'h40, 32'h11);
    wr(32'h40, 32'h22, 4'hF);
    rd(32'h40, 32'h22);
    drain();

    // Address alias wraps modulo WORDS*4.
    wr(32'h0, 32'hA5A5A5A5, 4'hF);
    rd(32'(WORDS * 4), 32'hA5A5A5A5);
    drain();

    // Reset with reads pending discards them but keeps the array.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd(32'h10, 32'hDEADBEEF);
    chk("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("midreset_rdata", rsp_payload_rdata, 32'd0);
    @(posedge clk);
    #3;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rd(32'h10, 32'hDEADBEEF);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
